// File: rtl/sqr_binary_seq.sv
// ---------------------------------------------------------------------------
// sqr_binary_seq
//
// Sequential inverse of the binary square-root unit: rebuilds the radicand
// p = u*u + r from a root u and a remainder r. The square is formed by
// shift-add, one multiplier bit per clock. The accumulator is seeded with r,
// so no separate final addition is needed.
//
// Transaction flow: IDLE accepts (u, r) on in_valid && in_ready. MUL runs
// HALF_SIZE iterations. DONE registers the result, then holds it until
// out_ready. The unit does not overlap transactions.
//
// Optional feature (compile-time macro SQR_REM_CHECK_EN):
//   defined   - flag r > 2u at accept and report it on rem_err with p.
//   undefined - no comparator is built and rem_err is tied to 0.
//
// Ports:
//   clk        in   1            clock, rising edge
//   rst        in   1            asynchronous reset, active high
//   in_valid   in   1            operands valid
//   in_ready   out  1            unit can accept operands (IDLE)
//   u          in   HALF_SIZE    root
//   r          in   HALF_SIZE+1  remainder (legal range 0..2u)
//   out_valid  out  1            result valid
//   out_ready  in   1            consumer accepts result
//   p          out  SIZE         u*u + r, modulo 2^SIZE
//   rem_err    out  1            remainder out of range (optional feature)
// ---------------------------------------------------------------------------
module sqr_binary_seq #(
  parameter int SIZE      = 16,
  parameter int HALF_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HALF_SIZE-1:0] u,
  input  logic [HALF_SIZE:0]   r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      p,
  output logic                 rem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold HALF_SIZE-1, the index of the last iteration.
  localparam int CW = $clog2(HALF_SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF_SIZE - 1);

  state_t                 state;
  logic [SIZE-1:0]        acc;    // running sum, seeded with r
  logic [SIZE-1:0]        mcand;  // u shifted left once per iteration
  logic [HALF_SIZE-1:0]   mplr;   // u shifted right; bit 0 selects the add
  logic [CW-1:0]          cnt;

  // Operands are zero-extended to the full accumulator width.
  logic [SIZE-1:0] u_ext;
  logic [SIZE-1:0] r_ext;
  assign u_ext = {{(SIZE - HALF_SIZE){1'b0}}, u};
  assign r_ext = {{(SIZE - HALF_SIZE - 1){1'b0}}, r};

`ifdef SQR_REM_CHECK_EN
  logic rem_flag;    // r > 2u, captured at accept
  logic rem_err_q;
  logic rem_bad;
  // Both sides are HALF_SIZE+2 bits wide, so 2u cannot overflow.
  assign rem_bad = {1'b0, r} > {1'b0, u, 1'b0};
  assign rem_err = rem_err_q;
`else
  assign rem_err = 1'b0;
`endif

  // NOTE: all state in this block uses non-blocking assignments, so every
  // branch reads the values from before the edge (e.g. acc with mplr[0]).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
`ifdef SQR_REM_CHECK_EN
      rem_flag  <= 1'b0;
      rem_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= u_ext;
            mplr     <= u;
            acc      <= r_ext;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
`ifdef SQR_REM_CHECK_EN
            rem_flag <= rem_bad;
`endif
          end
        end

        MUL: begin
          // The carry is discarded. Legal inputs never overflow, and illegal r wraps.
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CNT) state <= DONE;
        end

        DONE: begin
          if (!out_valid) begin
            // The first DONE cycle moves the finished sum into the output register.
            out_valid <= 1'b1;
            p         <= acc;
`ifdef SQR_REM_CHECK_EN
            rem_err_q <= rem_flag;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef SQR_REM_CHECK_EN
            rem_err_q <= 1'b0;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqr_binary_seq.sv
// ---------------------------------------------------------------------------
// tb_sqr_binary_seq
//
// Scoreboard bench for sqr_binary_seq (SIZE=16, HALF_SIZE=8). The stimulus
// pushes the hand-computed result for each accepted transaction. The monitor
// compares against that result whenever out_valid is high. It also checks
// the accept-to-valid latency and that in_ready stays low while a result is
// pending.
// ---------------------------------------------------------------------------
module tb_sqr_binary_seq;

  localparam int SIZE      = 16;
  localparam int HALF_SIZE = 8;
  localparam int LATENCY   = HALF_SIZE + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [HALF_SIZE-1:0] u = '0;
  logic [HALF_SIZE:0]   r = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [SIZE-1:0]      p;
  logic                 rem_err;

  sqr_binary_seq #(.SIZE(SIZE), .HALF_SIZE(HALF_SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .rem_err   (rem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] p;
    logic            err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   accept_edge = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          if (!prev_ov) check("latency", edge_cnt - accept_edge, LATENCY);
          check("p", p, q[0].p);
          check("rem_err", rem_err, q[0].err);
          check("in_ready_busy", in_ready, 1'b0);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // Present the operands and hold them until accepted. Then record the expected result.
  task automatic send(input int uu, input int rr);
    exp_t e;
    int   budget;
    @(posedge clk); #1;
    in_valid = 1'b1;
    u        = HALF_SIZE'(uu);
    r        = (HALF_SIZE+1)'(rr);
    budget   = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!in_ready && budget < 200);
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
    end else begin
      e.p = SIZE'(uu * uu + rr);
`ifdef SQR_REM_CHECK_EN
      e.err = (rr > 2 * uu);
`else
      e.err = 1'b0;
`endif
      q.push_back(e);
      accept_edge = edge_cnt + 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected result is consumed, then confirm the unit is ready again.
  task automatic wait_idle();
    int budget = 0;
    while (q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Check the reset state while operands are presented and rst is held.
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_p", p, 0);
    check("rst_rem_err", rem_err, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b0;

    // Basic results and boundary cases.
    send(12, 5);     wait_idle();   // 149
    send(255, 510);  wait_idle();   // 65535, largest legal result
    send(0, 0);      wait_idle();   // 0
    send(0, 9);      wait_idle();   // u=0: p=r
    send(255, 511);  wait_idle();   // illegal r, wraps to 0

    // Backpressure: the result must stay stable and in_ready must stay low.
    out_ready = 1'b0;
    send(100, 7);                   // 10007
    repeat (LATENCY + 20) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // in_valid pulses while busy must be ignored.
    send(200, 0);                   // 40000
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; u = 8'd1; r = 9'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; u = 8'd77; r = 9'd3;
    end
    wait_idle();
    send(1, 2);      wait_idle();   // 3

    // Reset in MUL cycle 4: the result is lost and out_valid must never rise.
    send(50, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_p", p, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid, 1'b0);
    end
    send(50, 0);     wait_idle();   // 2500

    // Remainder range check (rem_err is expected only with the macro).
    send(3, 7);      wait_idle();   // 16, r > 2u
    send(3, 6);      wait_idle();   // 15, r == 2u (legal)

    // Back-to-back legal random pairs.
    for (int i = 0; i < 100; i++) begin
      int ru;
      ru = $urandom_range(0, 255);
      send(ru, $urandom_range(0, 2 * ru));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
